// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register: 1-cycle latency; in_ready is combinational (base) or registered (PIPE_STAGE_SKID_EN).
// Stall holds contents. Flush wins over accept/consume. ctrl is zeroed on bubbles. bubble_cnt saturates.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              main_vld_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CNT_W-1:0]  bubble_q;
  logic [CNT_W-1:0]  bubble_d;

  assign out_valid  = main_vld_q;
  assign out_ctrl   = main_ctrl_q;
  assign out_data   = main_data_q;
  assign bubble_cnt = bubble_q;

  // A bubble cycle is one where downstream was ready but we had nothing to give.
  always_comb begin
    bubble_d = bubble_q;
    if (!main_vld_q && out_ready && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= '0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_q;
  logic              in_ready_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;

  assign in_ready = in_ready_q;

  // in_ready_q is low exactly when the skid entry is occupied (ST_SKID).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_vld_q  <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_vld_q  <= 1'b0;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid && in_ready_q) begin
            main_vld_q  <= 1'b1;
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
            state_q     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_valid && in_ready_q && out_ready) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
          end else if (in_valid && in_ready_q) begin
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
            in_ready_q  <= 1'b0;
            state_q     <= ST_SKID;
          end else if (out_ready) begin
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_FULL;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          main_vld_q  <= 1'b0;
          main_ctrl_q <= '0;
          skid_ctrl_q <= '0;
        end
      endcase
    end
  end

`else

  logic              accept;
  logic              consume;
  logic              main_vld_d;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_d;

  // Flush forces ready so upstream drains while the stage is discarded.
  assign in_ready = !main_vld_q || out_ready || flush;
  assign accept   = in_valid && in_ready;
  assign consume  = main_vld_q && out_ready;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    if (flush) begin
      main_vld_d  = 1'b0;
      main_ctrl_d = '0;
    end else if (accept) begin
      main_vld_d  = 1'b1;
      main_ctrl_d = in_ctrl;
      main_data_d = in_data;
    end else if (consume) begin
      main_vld_d  = 1'b0;
      main_ctrl_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q  <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed plus random bench for pipe_stage_reg against a queue-based model of the stage contents.
module tb_pipe_stage_reg;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 9;
  localparam int CNT_W  = 4;
  localparam int CNT_SAT = 15;

  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } item_t;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  bubble_cnt;

  item_t mq[$];
  item_t src[$];
  int    mcnt;
  int    total;
  int    passed;
  int    fails;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(input bit ordy, input bit fl);
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || ordy || fl;
`endif
  endfunction

  task automatic check_outputs();
    check("out_valid", out_valid, mq.size() > 0);
    check("out_ctrl", out_ctrl, (mq.size() > 0) ? mq[0].c : '0);
    if (mq.size() > 0) check("out_data", out_data, mq[0].d);
    check("bubble_cnt", bubble_cnt, mcnt);
  endtask

  task automatic push(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    item_t it;
    it.c = c;
    it.d = d;
    src.push_back(it);
  endtask

  task automatic cycle(input bit ordy, input bit fl);
    bit    rdy_exp;
    bit    acc;
    bit    con;
    item_t it;
    in_valid = (src.size() > 0);
    if (in_valid) begin
      in_ctrl = src[0].c;
      in_data = src[0].d;
    end else begin
      in_ctrl = CTRL_W'($urandom);
      in_data = {$urandom, $urandom, $urandom};
    end
    out_ready = ordy;
    flush     = fl;
    #1;
    rdy_exp = model_ready(ordy, fl);
    check("in_ready", in_ready, rdy_exp);
    @(posedge clk);
    acc = in_valid && rdy_exp;
    con = (mq.size() > 0) && ordy;
    if ((mq.size() == 0) && ordy && (mcnt < CNT_SAT)) mcnt++;
    if (acc) it = src.pop_front();
    if (fl) begin
      mq.delete();
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back(it);
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    total = 0; passed = 0; fails = 0; mcnt = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_bubble", bubble_cnt, 0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // Stream 1..8 at full rate.
    for (int i = 1; i <= 8; i++) push(CTRL_W'(i), DATA_W'(i));
    cycle(1'b1, 1'b0);
    check("stream_first_data", out_data, 1);
    check("stream_first_bubble", bubble_cnt, 1);
    repeat (9) cycle(1'b1, 1'b0);

    // Stall with A5 held, A6 waiting upstream.
    push(9'h0A5, 96'hA5);
    cycle(1'b0, 1'b0);
    push(9'h0A6, 96'hA6);
    repeat (3) cycle(1'b0, 1'b0);
    check("stall_hold", out_data, 96'hA5);
    repeat (3) cycle(1'b1, 1'b0);

    // Flush with a live input whose ctrl is all ones.
    push(9'h0A7, 96'hA7);
    cycle(1'b0, 1'b0);
    push(9'h1FF, 96'hF1F1);
    cycle(1'b0, 1'b1);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ctrl", out_ctrl, 0);
    repeat (2) cycle(1'b1, 1'b0);

    // Consume without new input zeroes ctrl.
    push(9'h13C, 96'hBEEF);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("bubble_zero_valid", out_valid, 1'b0);
    check("bubble_zero_ctrl", out_ctrl, 0);

    // Saturate the counter, then confirm flush leaves it alone.
    repeat (20) cycle(1'b1, 1'b0);
    check("sat", bubble_cnt, CNT_SAT);
    cycle(1'b1, 1'b1);
    check("sat_after_flush", bubble_cnt, CNT_SAT);

    // Asynchronous reset while stalled with both entries in use.
    push(9'h0B1, 96'hB1);
    push(9'h0B2, 96'hB2);
    push(9'h0B3, 96'hB3);
    repeat (3) cycle(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_ctrl", out_ctrl, 0);
    check("arst_data", out_data, 0);
    check("arst_bubble", bubble_cnt, 0);
    check("arst_in_ready", in_ready, 1'b1);
    mq.delete();
    src.delete();
    mcnt = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Random traffic with occasional flushes.
    repeat (400) begin
      if (($urandom_range(0, 2) != 0) && (src.size() < 4))
        push(CTRL_W'($urandom), {$urandom, $urandom, $urandom});
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register. It generalises the fixed inter-stage registers (ID→EXE, EXE→MEM, MEM→WB) into one block. It carries a generic payload plus a control field that is forced to zero whenever the stage holds a bubble. It adds a valid/ready stall handshake, a flush with priority, an optional skid buffer that registers the ready path, and a saturating bubble counter for performance debug.

## Interface
Parameters:
- DATA_W, 96, payload width; carries PC, Val_Rn, Val_Rm and similar fields, never interpreted.
- CTRL_W, 9, control width; carries WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD and similar fields; zeroed on bubbles.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discard stage contents and any concurrent input.
- in_valid  in  1  upstream holds a valid item.
- in_ready  out  1  stage can accept an item this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds a valid item.
- out_ready  in  1  downstream consumes the item this cycle.
- out_ctrl  out  CTRL_W  control field; 0 whenever out_valid=0.
- out_data  out  DATA_W  payload; don't-care when out_valid=0.
- bubble_cnt  out  CNT_W  saturating count of bubble cycles.

## Operation
- Accept means in_valid && in_ready at a clock edge. Consume means out_valid && out_ready at a clock edge.
- Base mode (no skid): one entry. in_ready = !out_valid || out_ready || flush, a combinational path.
  - On accept (no flush): out_data←in_data, out_ctrl←in_ctrl, out_valid←1.
  - On consume without accept: out_valid←0, out_ctrl←0. out_data holds its value.
  - With neither accept nor consume, all state holds; this is a stall.
- Flush has priority over everything else:
  - next out_valid=0 and out_ctrl=0;
  - an item accepted in the flush cycle is dropped;
  - in_ready=1 during flush, so upstream drains.
- Invariant: out_valid=0 implies out_ctrl=0. No write or branch enable ever leaks from a bubble.
- bubble_cnt increments by 1 in each cycle where out_valid=0 && out_ready=1 && !rst. It saturates at 2^CNT_W−1 and never wraps. It is cleared only by rst; flush does not clear it.
- Reset asserted mid-transfer clears all state immediately (asynchronous). Items in flight are lost.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, bubble_cnt=0, skid entry empty. in_ready=1 while rst is high and in the first cycle after release.
- Latency: an item accepted at edge N appears at out_* right after edge N. It can be consumed at edge N+1.
- Throughput: 1 item/cycle while out_ready=1, in both modes.
- out_valid, out_ctrl and out_data are registered outputs with no combinational input→output paths.
- Upstream must hold in_valid, in_ctrl and in_data stable while in_valid && !in_ready. Downstream may drop out_ready at any time.

## Configuration
- Macro PIPE_STAGE_SKID_EN.
- Defined: a second (skid) entry is added and in_ready becomes a pure register, in_ready = !skid_valid. The three states are:
  - EMPTY: accept → FULL.
  - FULL: accept && !consume → SKID, with the new item in the skid entry; accept && consume → FULL, main entry loaded from input; consume only → EMPTY.
  - SKID: in_ready=0; consume → FULL, main entry loaded from skid.
- Defined, flush: clears both entries → EMPTY, and in_ready=1 in the next cycle. The in_ready=1-during-flush rule does not apply; an accept in the flush cycle is dropped.
- Undefined: base single-entry behaviour only, and no skid storage is synthesised.

## Test plan
- Reset then stream: in_valid=1 with data 0x1..0x8 and out_ready=1 → out_data 0x1..0x8 on consecutive cycles one cycle later; bubble_cnt=1 (the cycle before the first item arrives).
- Stall: hold out_ready=0 for 3 cycles with item 0xA5 → out_data=0xA5 held; base mode in_ready=0; skid mode accepts one more item (0xA6), then in_ready=0; after release, order is 0xA5, 0xA6 with no loss or duplication.
- Flush with in_valid=1, in_ctrl=0x1FF during flush → next cycle out_valid=0 and out_ctrl=0x000; the flushed item never appears.
- Bubble zeroing: consume with no new input → out_ctrl=0 in the following cycle, out_valid=0.
- Saturation with CNT_W=4: 20 idle cycles with out_ready=1 → bubble_cnt=15 and holds; flush leaves it at 15.
- Async reset mid-stall (skid full) → all outputs 0 within the same cycle; in_ready=1.
